mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/tinyrv1_mem_pkg.sv | 15 +
 rtl/mem_responder_register.sv | 20 ++
 rtl/mem_responder.sv | 79 +++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/tinyrv1_mem_pkg.sv
// Shared memory request/response definitions.
// Imported by the processor, the memory responder and the test harness.
package tinyrv1_mem_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef struct packed {
    logic        val;
    logic        rtype;
    logic        err;
    logic [31:0] rdata;
  } memresp_t;

endpackage

// File: rtl/mem_responder_register.sv
// Generic register with enable and synchronous active-high reset to zero.
// Ports: clk, rst, en, d (p_width), q (p_width).
module mem_responder_register #(
  parameter int p_width = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [p_width-1:0] d,
  output logic [p_width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word memory answering every valid request in order.
// Ports: clk, rst, memreq_{val,type,addr,wdata} in; memresp_{val,type,rdata,err} out.
import tinyrv1_mem_pkg::*;

module mem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreq_val,
  input  logic        memreq_type,
  input  logic [31:0] memreq_addr,
  input  logic [31:0] memreq_wdata,
  output logic        memresp_val,
  output logic        memresp_type,
  output logic [31:0] memresp_rdata,
  output logic        memresp_err
);

  localparam int AW = $clog2(p_num_words);

  logic [31:0]  mem [p_num_words];
  logic [AW-1:0] idx;
  logic         accept;
  logic         aligned;
  logic         wr_en;
  memresp_t     req_resp;

  memresp_t [p_latency:0] pipe;

  // Upper address bits are dropped so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^memreq_addr[31:2+AW];

  assign idx     = memreq_addr[2 +: AW];
  assign accept  = memreq_val & ~rst;
  assign aligned = (memreq_addr[1:0] == 2'b00);
  assign wr_en   = accept & aligned
                 & (memreq_type == MEMREQ_WRITE);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx] <= memreq_wdata;
  end

  // Idle slots carry an all-zero bundle so the
  // outputs read zero without extra gating.
  always_comb begin
    req_resp = '0;
    if (accept) begin
      req_resp.val   = 1'b1;
      req_resp.rtype = memreq_type;
      req_resp.err   = ~aligned;
      if (aligned && memreq_type == MEMREQ_READ)
        req_resp.rdata = mem[idx];
    end
  end

  assign pipe[0] = req_resp;

  for (genvar i = 0; i < p_latency; i++) begin : g_stage
    mem_responder_register #(
      .p_width ($bits(memresp_t))
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (pipe[i]),
      .q   (pipe[i+1])
    );
  end

  assign memresp_val   = pipe[p_latency].val;
  assign memresp_type  = pipe[p_latency].rtype;
  assign memresp_err   = pipe[p_latency].err;
  assign memresp_rdata = pipe[p_latency].rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (latency 1, 3, 4) share one
// request stream and are compared against a cycle-history reference model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        memreq_val;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;

  logic        r1_val, r3_val, r4_val;
  logic        r1_type, r3_type, r4_type;
  logic        r1_err, r3_err, r4_err;
  logic [31:0] r1_rdata, r3_rdata, r4_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam int HMAX = 2048;

  // Per-cycle history: reset flag and the response a request earns.
  logic        rst_h  [HMAX];
  logic [34:0] resp_h [HMAX];
  logic [31:0] mdl    [256];

  always #5 clk = ~clk;

  mem_responder #(.p_num_words(256), .p_latency(1)) dut1 (
    .clk (clk), .rst (rst),
    .memreq_val (memreq_val), .memreq_type (memreq_type),
    .memreq_addr (memreq_addr), .memreq_wdata (memreq_wdata),
    .memresp_val (r1_val), .memresp_type (r1_type),
    .memresp_rdata (r1_rdata), .memresp_err (r1_err)
  );

  mem_responder #(.p_num_words(256), .p_latency(3)) dut3 (
    .clk (clk), .rst (rst),
    .memreq_val (memreq_val), .memreq_type (memreq_type),
    .memreq_addr (memreq_addr), .memreq_wdata (memreq_wdata),
    .memresp_val (r3_val), .memresp_type (r3_type),
    .memresp_rdata (r3_rdata), .memresp_err (r3_err)
  );

  mem_responder #(.p_num_words(256), .p_latency(4)) dut4 (
    .clk (clk), .rst (rst),
    .memreq_val (memreq_val), .memreq_type (memreq_type),
    .memreq_addr (memreq_addr), .memreq_wdata (memreq_wdata),
    .memresp_val (r4_val), .memresp_type (r4_type),
    .memresp_rdata (r4_rdata), .memresp_err (r4_err)
  );

  // Response visible in cycle c for latency lat: the request from c-lat,
  // unless reset was high in any cycle from its acceptance up to c-1.
  function automatic logic [34:0] expect_at(int c, int lat);
    if (c - lat < 0) return '0;
    for (int k = c - lat; k < c; k++)
      if (rst_h[k]) return '0;
    return resp_h[c-lat];
  endfunction

  task automatic chk(input string tag,
                     input logic [34:0] obs,
                     input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic ty,
                      input logic [31:0] a, input logic [31:0] d);
    logic        al;
    logic [31:0] rd;
    rst          = r;
    memreq_val   = v;
    memreq_type  = ty;
    memreq_addr  = a;
    memreq_wdata = d;
    @(negedge clk);
    if (cyc > 0) begin
      chk("lat1", {r1_val, r1_type, r1_err, r1_rdata}, expect_at(cyc, 1));
      chk("lat3", {r3_val, r3_type, r3_err, r3_rdata}, expect_at(cyc, 3));
      chk("lat4", {r4_val, r4_type, r4_err, r4_rdata}, expect_at(cyc, 4));
    end
    rst_h[cyc]  = r;
    resp_h[cyc] = '0;
    if (v && !r) begin
      al = (a[1:0] == 2'b00);
      rd = (al && !ty) ? mdl[a[9:2]] : 32'h0;
      resp_h[cyc] = {1'b1, ty, !al, rd};
      if (al && ty) mdl[a[9:2]] = d;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic r, v, ty;

    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h8, 32'h1234);
    idle(2);

    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 1'b1, 32'(i * 4), $urandom);
    idle(4);

    // Write then read.
    step(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("s1_wr", {r1_val, r1_type, r1_err, r1_rdata}, {3'b110, 32'h0});
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("s1_rd", {r1_val, r1_type, r1_err, r1_rdata},
        {3'b100, 32'hDEADBEEF});
    idle(4);

    // Streaming reads.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(4);

    // Misaligned write leaves memory untouched.
    step(1'b0, 1'b1, 1'b1, 32'h13, 32'h1);
    chk("s3_err", {r1_val, r1_type, r1_err, r1_rdata}, {3'b111, 32'h0});
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("s3_rd", {r1_val, r1_type, r1_err, r1_rdata},
        {3'b100, 32'hDEADBEEF});
    idle(4);

    // Wrap-around.
    step(1'b0, 1'b1, 1'b1, 32'h400, 32'h55);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("s4_wrap", {r1_val, r1_type, r1_err, r1_rdata}, {3'b100, 32'h55});
    idle(4);

    // Reset mid-flight.
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("s5_drop", {34'h0, r4_val}, 35'h0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    idle(3);
    chk("s5_rd", {r4_val, r4_type, r4_err, r4_rdata},
        {3'b100, 32'hDEADBEEF});
    idle(4);

    // Idle.
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("s6_idle", {r1_val, r1_type, r1_err, r1_rdata}, 35'h0);
    end

    // Random traffic over the preloaded words, with aliasing high bits.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ty = 1'($urandom_range(0, 1));
      a  = $urandom;
      a[9:6] = 4'h0;
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3))
                                           : 2'b00;
      step(r, v, ty, a, $urandom);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
